// File: rtl/boot_loader.sv
// Boot-stream loader: receives a length-prefixed, XOR-checksummed image over a byte
// handshake, writes it word by word into IMEM and releases the CPU from reset.
module boot_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_imem_we,
  output logic [63:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_reset,
  output logic        o_boot_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    StCntLo, StCntHi, StData, StWrite, StCheck, StDone, StError
  } state_e;

  state_e      r_state;
  logic [15:0] r_count;
  logic [15:0] r_idx;
  logic [7:0]  r_csum;
  logic [31:0] r_wdata;
  logic [1:0]  r_bsel;

  logic        w_accept;
  logic [15:0] w_count_full;

  assign w_accept     = i_rx_valid && o_rx_ready;
  assign w_count_full = {i_rx_data, r_count[7:0]};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StCntLo;
      r_count <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
      r_wdata <= '0;
      r_bsel  <= '0;
    end else begin
      unique case (r_state)
        StCntLo: if (w_accept) begin
          r_count[7:0] <= i_rx_data;
          r_csum       <= r_csum ^ i_rx_data;
          r_state      <= StCntHi;
        end
        StCntHi: if (w_accept) begin
          r_count <= w_count_full;
          r_csum  <= r_csum ^ i_rx_data;
          r_bsel  <= '0;
          if (w_count_full == 16'd0)                   r_state <= StCheck;
          else if (32'(w_count_full) > MAX_WORDS)      r_state <= StError;
          else                                         r_state <= StData;
        end
        StData: if (w_accept) begin
          r_wdata[{r_bsel, 3'b000} +: 8] <= i_rx_data;
          r_csum  <= r_csum ^ i_rx_data;
          r_bsel  <= r_bsel + 2'd1;
          if (r_bsel == 2'd3) r_state <= StWrite;
        end
        StWrite: begin
          r_idx   <= r_idx + 16'd1;
          r_state <= (r_idx + 16'd1 == r_count) ? StCheck : StData;
        end
        StCheck: if (w_accept) begin
          r_state <= (i_rx_data == r_csum) ? StDone : StError;
        end
        StDone, StError: r_state <= r_state;
        default: r_state <= StError;
      endcase
    end
  end

  // Gating with i_reset keeps the outputs in their safe values during the reset cycle itself,
  // including suppressing a pending IMEM write.
  assign o_rx_ready   = i_reset && (r_state inside {StCntLo, StCntHi, StData, StCheck});
  assign o_imem_we    = i_reset && (r_state == StWrite);
  assign o_imem_addr  = BASE_ADDR + {46'd0, r_idx, 2'b00};
  assign o_imem_wdata = r_wdata;
  assign o_boot_done  = i_reset && (r_state == StDone);
  assign o_err        = i_reset && (r_state == StError);
  assign o_cpu_reset  = !o_boot_done;

endmodule
